// File: rtl/measure_sequencer.sv
// Frequency measurement sequencer: counts rising edges of IN over a gate window, hands the count
// to a binary-to-BCD converter and publishes it. Optional input glitch filter: MEAS_GLITCH_FILTER_EN.
module measure_sequencer #(
    parameter int unsigned GATE_CYCLES  = 100000000,
    parameter int unsigned CNT_W        = 14,
    parameter int unsigned MAX_COUNT    = 9999,
    parameter int unsigned CONV_TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             IN,
    input  logic             run,
    input  logic             single,
    output logic             conv_req,
    output logic [CNT_W-1:0] conv_bin,
    input  logic             conv_ack,
    output logic             disp_load,
    output logic [CNT_W-1:0] freq,
    output logic             ovf,
    output logic             conv_err,
    output logic             busy
);

    localparam int unsigned GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned TMO_W  = (CONV_TIMEOUT > 2) ? $clog2(CONV_TIMEOUT) : 1;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(CONV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_COUNT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_GATE    = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_CONVERT = 3'd4;
    localparam logic [2:0] S_HOLD    = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic              in_meta;
    logic              in_sync;
    logic              edge_src;
    logic              in_prev;
    logic              edge_pls;
    logic [GATE_W-1:0] gate_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              ovf_flag;
    logic              gate_end;
    logic              tmo_end;

    // Two-flop synchronizer for the asynchronous signal under test
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            in_meta <= 1'b0;
            in_sync <= 1'b0;
        end else begin
            in_meta <= IN;
            in_sync <= in_meta;
        end
    end

`ifdef MEAS_GLITCH_FILTER_EN
    logic in_sync_d;
    logic in_filt;

    // Filtered level only follows the input once it has been stable for two samples
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            in_sync_d <= 1'b0;
            in_filt   <= 1'b0;
        end else begin
            in_sync_d <= in_sync;
            if (in_sync == in_sync_d) begin
                in_filt <= in_sync;
            end
        end
    end

    assign edge_src = in_filt;
`else
    assign edge_src = in_sync;
`endif

    // Registered rising-edge pulse
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            in_prev  <= 1'b0;
            edge_pls <= 1'b0;
        end else begin
            in_prev  <= edge_src;
            edge_pls <= edge_src & ~in_prev;
        end
    end

    assign gate_end = (gate_cnt == GATE_LAST);
    assign tmo_end  = (tmo_cnt == TMO_LAST);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (run || single) state_nx = S_ARM;
            S_ARM:     state_nx = S_GATE;
            S_GATE:    if (gate_end) state_nx = S_LATCH;
            S_LATCH:   state_nx = S_CONVERT;
            S_CONVERT: if (conv_ack || tmo_end) state_nx = S_HOLD;
            S_HOLD:    state_nx = run ? S_ARM : S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Counters, converter handshake and published result
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            gate_cnt  <= '0;
            tmo_cnt   <= '0;
            edge_cnt  <= '0;
            ovf_flag  <= 1'b0;
            conv_req  <= 1'b0;
            conv_bin  <= '0;
            disp_load <= 1'b0;
            freq      <= '0;
            ovf       <= 1'b0;
            conv_err  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            disp_load <= 1'b0;
            conv_req  <= (state_nx == S_CONVERT);
            busy      <= (state_nx != S_IDLE);
            case (state)
                S_ARM: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf_flag <= 1'b0;
                end
                S_GATE: begin
                    gate_cnt <= gate_cnt + GATE_W'(1);
                    if (edge_pls) begin
                        if (edge_cnt == CNT_MAX) begin
                            ovf_flag <= 1'b1;
                        end else begin
                            edge_cnt <= edge_cnt + CNT_W'(1);
                        end
                    end
                end
                S_LATCH: begin
                    conv_bin <= edge_cnt;
                    tmo_cnt  <= '0;
                end
                S_CONVERT: begin
                    // An acknowledge on the last allowed cycle still wins over the timeout
                    if (conv_ack) begin
                        disp_load <= 1'b1;
                        freq      <= conv_bin;
                        ovf       <= ovf_flag;
                        conv_err  <= 1'b0;
                    end else if (tmo_end) begin
                        conv_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
